// File: rtl/ld_insn_scheduler.sv
// ld_insn_scheduler
//
// Schedules load instructions from two requesters onto one address generator.
// Requester 0 is the input-load queue and requester 1 is the weight-load queue.
// Arbitration is round-robin. Each accepted instruction runs through the
// states IDLE -> CHECK -> ISSUE -> BUSY -> DONE. A rejected instruction goes
// from CHECK straight to DONE.
//
// Handshake: a request transfers on the rising clk edge where
// req_valid[i] && req_ready[i]. The requester holds req_valid and req_insn
// stable until that edge. req_ready is high only in IDLE and only for the
// granted index.
//
// Ports
//   clk, reset_n            clock; synchronous active-low reset
//   req_valid/req_ready     per-requester instruction handshake (2 bits)
//   req_insn                two packed instructions; requester i occupies
//                           bits [i*INSN_W +: INSN_W]
//   done                    one-cycle completion pulse to the owner requester
//   done_load_cnt/done_err  completion payload; valid only while done is high
//   busy                    high whenever the FSM is not in IDLE
//   gen_start               one-cycle start pulse to the address generator
//   gen_*                   registered generator configuration
//   gen_insn_done           generator instruction-complete level
//   gen_load_done           generator per-tile load-done level
module ld_insn_scheduler #(
    parameter int INP_NUM_W   = 10,
    parameter int INSN_UOP_W  = 16,
    parameter int INSN_ITER_W = 16,
    parameter int INSN_FAC_W  = 16,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_W   = 20,
    localparam int INSN_W = INP_NUM_W + 2*INSN_UOP_W + 1 + 2*INSN_ITER_W + 2*INSN_FAC_W
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [2*INSN_W-1:0]     req_insn,
    output logic [1:0]              done,
    output logic [CNT_W-1:0]        done_load_cnt,
    output logic                    done_err,
    output logic                    busy,
    output logic                    gen_start,
    output logic [INP_NUM_W-1:0]    gen_inp_num,
    output logic [INSN_UOP_W-1:0]   gen_uop_bgn,
    output logic [INSN_UOP_W:0]     gen_uop_end,
    output logic [INSN_ITER_W-1:0]  gen_iter_in,
    output logic [INSN_ITER_W-1:0]  gen_iter_out,
    output logic [INSN_FAC_W-1:0]   gen_factor_in,
    output logic [INSN_FAC_W-1:0]   gen_factor_out,
    input  logic                    gen_insn_done,
    input  logic                    gen_load_done
);

    // Field offsets inside a packed instruction, LSB first.
    localparam int OFS_UOP_BGN = INP_NUM_W;
    localparam int OFS_UOP_END = OFS_UOP_BGN + INSN_UOP_W;
    localparam int OFS_ITER_IN = OFS_UOP_END + INSN_UOP_W + 1;
    localparam int OFS_ITER_OUT = OFS_ITER_IN + INSN_ITER_W;
    localparam int OFS_FAC_IN  = OFS_ITER_OUT + INSN_ITER_W;
    localparam int OFS_FAC_OUT = OFS_FAC_IN + INSN_FAC_W;

    localparam logic [CNT_W-1:0]     CNT_MAX = '1;
    // The watchdog fires in the BUSY cycle where its next value would be
    // all-ones. With TIMEOUT_W = 4 that is the 15th BUSY cycle.
    localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ISSUE = 3'd2,
        BUSY  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                 state, state_next;
    logic                   prio;
    logic                   owner;
    logic                   err;
    logic [CNT_W-1:0]       load_cnt;
    logic [TIMEOUT_W-1:0]   wd_cnt;

    logic                   grant_any;
    logic                   grant_idx;
    logic                   accept;
    logic [INSN_W-1:0]      sel_insn;
    logic                   reject;
    logic                   guard_cycle;
    logic                   insn_done_ok;
    logic                   timeout_hit;

    // Grant: a lone valid requester wins; on contention prio decides.
    always_comb begin
        grant_any = |req_valid;
        grant_idx = (req_valid == 2'b11) ? prio : req_valid[1];
        req_ready = 2'b00;
        if (state == IDLE && grant_any) begin
            req_ready = grant_idx ? 2'b10 : 2'b01;
        end
        accept   = |(req_valid & req_ready);
        sel_insn = grant_idx ? req_insn[2*INSN_W-1:INSN_W] : req_insn[INSN_W-1:0];
    end

    always_comb begin
        reject = (gen_iter_out == '0) || (gen_iter_in == '0) ||
                 (gen_uop_end <= {1'b0, gen_uop_bgn});
        // Watchdog is zero only in the first BUSY cycle; the generator's
        // insn_done level may still reflect the previous instruction there.
        guard_cycle  = (wd_cnt == '0);
        insn_done_ok = gen_insn_done && !guard_cycle;
        timeout_hit  = (wd_cnt == WD_LAST);
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CHECK;
            CHECK:   state_next = reject ? DONE : ISSUE;
            ISSUE:   state_next = BUSY;
            BUSY:    if (insn_done_ok || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        busy          = (state != IDLE);
        gen_start     = (state == ISSUE);
        done          = 2'b00;
        done_load_cnt = '0;
        done_err      = 1'b0;
        if (state == DONE) begin
            done          = owner ? 2'b10 : 2'b01;
            done_load_cnt = load_cnt;
            done_err      = err;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            prio           <= 1'b0;
            owner          <= 1'b0;
            err            <= 1'b0;
            load_cnt       <= '0;
            wd_cnt         <= '0;
            gen_inp_num    <= '0;
            gen_uop_bgn    <= '0;
            gen_uop_end    <= '0;
            gen_iter_in    <= '0;
            gen_iter_out   <= '0;
            gen_factor_in  <= '0;
            gen_factor_out <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        gen_inp_num    <= sel_insn[0 +: INP_NUM_W];
                        gen_uop_bgn    <= sel_insn[OFS_UOP_BGN +: INSN_UOP_W];
                        gen_uop_end    <= sel_insn[OFS_UOP_END +: INSN_UOP_W+1];
                        gen_iter_in    <= sel_insn[OFS_ITER_IN +: INSN_ITER_W];
                        gen_iter_out   <= sel_insn[OFS_ITER_OUT +: INSN_ITER_W];
                        gen_factor_in  <= sel_insn[OFS_FAC_IN +: INSN_FAC_W];
                        gen_factor_out <= sel_insn[OFS_FAC_OUT +: INSN_FAC_W];
                        owner          <= grant_idx;
                        prio           <= ~grant_idx;
                        load_cnt       <= '0;
                        err            <= 1'b0;
                    end
                end
                CHECK: begin
                    if (reject) err <= 1'b1;
                end
                ISSUE: begin
                    wd_cnt <= '0;
                end
                BUSY: begin
                    wd_cnt <= wd_cnt + TIMEOUT_W'(1);
                    if (gen_load_done && load_cnt != CNT_MAX) begin
                        load_cnt <= load_cnt + CNT_W'(1);
                    end
                    // insn_done takes precedence over a simultaneous timeout.
                    if (!insn_done_ok && timeout_hit) err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ld_insn_scheduler.sv
// Directed testbench for ld_insn_scheduler (watchdog width reduced to 4).
module tb_ld_insn_scheduler;

    localparam int INP_NUM_W   = 10;
    localparam int INSN_UOP_W  = 16;
    localparam int INSN_ITER_W = 16;
    localparam int INSN_FAC_W  = 16;
    localparam int CNT_W       = 16;
    localparam int TIMEOUT_W   = 4;
    localparam int INSN_W = INP_NUM_W + 2*INSN_UOP_W + 1 + 2*INSN_ITER_W + 2*INSN_FAC_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [1:0]              req_valid;
    logic [1:0]              req_ready;
    logic [2*INSN_W-1:0]     req_insn;
    logic [1:0]              done;
    logic [CNT_W-1:0]        done_load_cnt;
    logic                    done_err;
    logic                    busy;
    logic                    gen_start;
    logic [INP_NUM_W-1:0]    gen_inp_num;
    logic [INSN_UOP_W-1:0]   gen_uop_bgn;
    logic [INSN_UOP_W:0]     gen_uop_end;
    logic [INSN_ITER_W-1:0]  gen_iter_in;
    logic [INSN_ITER_W-1:0]  gen_iter_out;
    logic [INSN_FAC_W-1:0]   gen_factor_in;
    logic [INSN_FAC_W-1:0]   gen_factor_out;
    logic                    gen_insn_done;
    logic                    gen_load_done;

    ld_insn_scheduler #(
        .INP_NUM_W(INP_NUM_W), .INSN_UOP_W(INSN_UOP_W), .INSN_ITER_W(INSN_ITER_W),
        .INSN_FAC_W(INSN_FAC_W), .CNT_W(CNT_W), .TIMEOUT_W(TIMEOUT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_insn(req_insn),
        .done(done), .done_load_cnt(done_load_cnt), .done_err(done_err),
        .busy(busy), .gen_start(gen_start),
        .gen_inp_num(gen_inp_num), .gen_uop_bgn(gen_uop_bgn), .gen_uop_end(gen_uop_end),
        .gen_iter_in(gen_iter_in), .gen_iter_out(gen_iter_out),
        .gen_factor_in(gen_factor_in), .gen_factor_out(gen_factor_out),
        .gen_insn_done(gen_insn_done), .gen_load_done(gen_load_done)
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [INSN_W-1:0] pack(
        input logic [INP_NUM_W-1:0]   inp,
        input logic [INSN_UOP_W-1:0]  ub,
        input logic [INSN_UOP_W:0]    ue,
        input logic [INSN_ITER_W-1:0] ii,
        input logic [INSN_ITER_W-1:0] io,
        input logic [INSN_FAC_W-1:0]  fi,
        input logic [INSN_FAC_W-1:0]  fo);
        return {fo, fi, io, ii, ue, ub, inp};
    endfunction

    task automatic set_insn(input int idx, input logic [INSN_W-1:0] insn);
        req_insn[idx*INSN_W +: INSN_W] = insn;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_n = 1'b0;
        req_valid = 2'b00;
        req_insn = '0;
        gen_insn_done = 1'b0;
        gen_load_done = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(gen_start), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cnt", 32'(done_load_cnt), 0);
        chk("rst_err", 32'(done_err), 0);
        chk("rst_inp", 32'(gen_inp_num), 0);
        chk("rst_uend", 32'(gen_uop_end), 0);
        chk("rst_ready", 32'(req_ready), 0);
        reset_n = 1'b1;
        tick();

        // ---- Test 1: single request on bit0, 3 load_done cycles ----
        set_insn(0, pack(10'd4, 16'd0, 17'd8, 16'd2, 16'd1, 16'd16, 16'd64));
        req_valid = 2'b01;
        #1;
        chk("t1_ready", 32'(req_ready), 32'b01);
        tick();                               // accept edge -> CHECK (+1)
        req_valid = 2'b00;
        chk("t1_chk_busy", 32'(busy), 1);
        chk("t1_chk_start", 32'(gen_start), 0);
        chk("t1_inp", 32'(gen_inp_num), 4);
        chk("t1_uend", 32'(gen_uop_end), 8);
        chk("t1_iin", 32'(gen_iter_in), 2);
        chk("t1_fin", 32'(gen_factor_in), 16);
        chk("t1_fout", 32'(gen_factor_out), 64);
        tick();                               // ISSUE (+2)
        chk("t1_start", 32'(gen_start), 1);
        tick();                               // BUSY1
        chk("t1_busy1_start", 32'(gen_start), 0);
        gen_load_done = 1'b1;
        tick();                               // BUSY2
        tick();                               // BUSY3
        gen_insn_done = 1'b1;
        chk("t1_busy3_done", 32'(done), 0);
        tick();                               // DONE
        gen_insn_done = 1'b0;
        gen_load_done = 1'b0;
        chk("t1_done", 32'(done), 32'b01);
        chk("t1_cnt", 32'(done_load_cnt), 3);
        chk("t1_err", 32'(done_err), 0);
        tick();                               // IDLE
        chk("t1_idle_done", 32'(done), 0);
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_cfg_hold", 32'(gen_iter_in), 2);

        // ---- Test 2: both valid, alternating grants from bit0; stale insn_done ----
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        set_insn(0, pack(10'd1, 16'd2, 17'd6, 16'd1, 16'd1, 16'd3, 16'd4));
        set_insn(1, pack(10'd2, 16'd7, 17'd9, 16'd5, 16'd5, 16'd6, 16'd8));
        req_valid = 2'b11;
        gen_insn_done = 1'b1;                 // held high: stale in BUSY1
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t2_ready", 32'(req_ready), (k % 2 == 0) ? 32'b01 : 32'b10);
            tick();                           // CHECK
            chk("t2_ready_chk", 32'(req_ready), 0);
            chk("t2_inp", 32'(gen_inp_num), (k % 2 == 0) ? 32'd1 : 32'd2);
            tick();                           // ISSUE
            chk("t2_start", 32'(gen_start), 1);
            tick();                           // BUSY1, insn_done ignored
            chk("t2_busy1", 32'(done), 0);
            tick();                           // BUSY2
            chk("t2_busy2_done", 32'(done), 0);
            chk("t2_busy2_busy", 32'(busy), 1);
            tick();                           // DONE
            chk("t2_done", 32'(done), (k % 2 == 0) ? 32'b01 : 32'b10);
            chk("t2_err", 32'(done_err), 0);
            tick();                           // IDLE
        end
        req_valid = 2'b00;
        gen_insn_done = 1'b0;

        // ---- Test 3: rejects (load_done held high must not count) ----
        gen_load_done = 1'b1;
        set_insn(0, pack(10'd3, 16'd0, 17'd4, 16'd1, 16'd0, 16'd1, 16'd1));
        req_valid = 2'b01;
        #1;
        chk("t3a_ready", 32'(req_ready), 32'b01);
        tick();                               // CHECK
        req_valid = 2'b00;
        chk("t3a_start_chk", 32'(gen_start), 0);
        tick();                               // DONE at +2
        chk("t3a_start_done", 32'(gen_start), 0);
        chk("t3a_done", 32'(done), 32'b01);
        chk("t3a_err", 32'(done_err), 1);
        chk("t3a_cnt", 32'(done_load_cnt), 0);
        tick();                               // IDLE
        set_insn(1, pack(10'd3, 16'd5, 17'd5, 16'd1, 16'd1, 16'd1, 16'd1));
        req_valid = 2'b10;
        #1;
        chk("t3b_ready", 32'(req_ready), 32'b10);
        tick();
        req_valid = 2'b00;
        chk("t3b_start_chk", 32'(gen_start), 0);
        tick();
        chk("t3b_done", 32'(done), 32'b10);
        chk("t3b_err", 32'(done_err), 1);
        chk("t3b_cnt", 32'(done_load_cnt), 0);
        tick();
        gen_load_done = 1'b0;

        // ---- Test 4: watchdog, then insn_done in the timeout cycle ----
        for (int run = 0; run < 2; run++) begin
            set_insn(0, pack(10'd9, 16'd1, 17'd3, 16'd1, 16'd1, 16'd2, 16'd2));
            req_valid = 2'b01;
            tick();                           // CHECK
            req_valid = 2'b00;
            tick();                           // ISSUE
            chk("t4_start", 32'(gen_start), 1);
            tick();                           // BUSY1
            gen_load_done = 1'b1;
            for (int b = 2; b <= 15; b++) begin
                tick();                       // BUSY b
                chk("t4_wait", 32'(done), 0);
            end
            if (run == 1) gen_insn_done = 1'b1;
            tick();                           // DONE
            gen_load_done = 1'b0;
            gen_insn_done = 1'b0;
            chk("t4_done", 32'(done), 32'b01);
            chk("t4_err", 32'(done_err), (run == 0) ? 32'd1 : 32'd0);
            chk("t4_cnt", 32'(done_load_cnt), 15);
            tick();                           // IDLE
        end

        // ---- Test 5: reset in BUSY aborts; bit0 wins afterwards ----
        set_insn(0, pack(10'd11, 16'd0, 17'd2, 16'd1, 16'd1, 16'd1, 16'd1));
        set_insn(1, pack(10'd22, 16'd0, 17'd2, 16'd1, 16'd1, 16'd1, 16'd1));
        req_valid = 2'b01;
        tick();                               // CHECK (prio -> 1)
        req_valid = 2'b00;
        tick();                               // ISSUE
        tick();                               // BUSY1
        gen_insn_done = 1'b1;
        tick();                               // BUSY2
        reset_n = 1'b0;
        tick();                               // reset applied
        chk("t5_busy", 32'(busy), 0);
        chk("t5_done", 32'(done), 0);
        chk("t5_start", 32'(gen_start), 0);
        chk("t5_inp", 32'(gen_inp_num), 0);
        chk("t5_iout", 32'(gen_iter_out), 0);
        gen_insn_done = 1'b0;
        reset_n = 1'b1;
        tick();
        chk("t5_nodone", 32'(done), 0);
        req_valid = 2'b11;
        #1;
        chk("t5_ready", 32'(req_ready), 32'b01);
        tick();
        req_valid = 2'b00;
        chk("t5_inp_after", 32'(gen_inp_num), 11);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
